memory_round_ctrl: RTL and testbench

Game-side round controller for the memory game, opposite the player interface. It presents a 10-bit pattern on the LEDs for a fixed time, blanks them, and waits for the player to set the switches and press the submit key. It then scores the guess, maintains correct/incorrect counters and a percentage score, and returns to accept the next pattern. It sits between the pattern source (LFSR) and the hex/LED display logic inside memory_game_main.

---
 rtl/memory_game_pkg.sv | 16 +
 rtl/pct_divider.sv | 60 ++++++
 rtl/memory_round_ctrl.sv | 153 +++++++++++++++
 tb/tb_memory_round_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared state encoding, key indices and score scale for the memory game
package memory_game_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOW     = 3'd1,
    BLANK    = 3'd2,
    WAIT_KEY = 3'd3,
    CHECK    = 3'd4,
    DIV      = 3'd5,
    RESULT   = 3'd6
  } state_t;
  localparam int KEY_SUBMIT = 3;
  localparam int KEY_REPLAY = 2;
  localparam int KEY_CLEAR  = 1;
  localparam int PCT_SCALE  = 100;
endpackage

// File: rtl/pct_divider.sv
// pct_divider: 14/8 restoring divider producing a 7-bit quotient, one bit per cycle plus a done cycle
module pct_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] num,
  input  logic [7:0]  den,
  output logic        done,
  output logic [6:0]  quo
);
  logic [7:0] rem_q, rem_d, den_q, den_d;
  logic [6:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, zero_q, zero_d, ge;
  logic [8:0] t;
  assign t  = {rem_q, sh_q[6]};
  assign ge = t >= {1'b0, den_q};
  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    zero_d = zero_q;
    if (start) begin
      rem_d  = {1'b0, num[13:7]};
      sh_d   = num[6:0];
      den_d  = den;
      cnt_d  = '0;
      busy_d = 1'b1;
      zero_d = den == '0;
    end else if (busy_q) begin
      cnt_d  = cnt_q + 3'd1;
      busy_d = cnt_q != 3'd7;
      if (cnt_q != 3'd7) begin
        rem_d = ge ? 8'(t - {1'b0, den_q}) : t[7:0];
        sh_d  = {sh_q[5:0], ge};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      zero_q <= zero_d;
    end
  end
  assign done = busy_q && cnt_q == 3'd7;
  assign quo  = zero_q ? '0 : sh_q;
endmodule

// File: rtl/memory_round_ctrl.sv
// memory_round_ctrl: memory game round FSM with debounced keys, scoring and percent score
module memory_round_ctrl #(
  parameter int SHOW_CYCLES   = 25000000,
  parameter int BLANK_CYCLES  = 5000000,
  parameter int RESULT_CYCLES = 25000000,
  parameter int DEB_CYCLES    = 500000,
  parameter int MAX_COUNT     = 99
) (
  input  logic       clock_50M,
  input  logic       reset,
  input  logic [9:0] pattern,
  input  logic       pattern_valid,
  output logic       pattern_ready,
  input  logic [9:0] sw,
  input  logic [3:1] key,
  output logic [9:0] led,
  output logic [2:0] display_state,
  output logic [6:0] correct,
  output logic [6:0] incorrect,
  output logic [6:0] percent,
  output logic       round_done,
  output logic       round_ok
);
  import memory_game_pkg::*;
  localparam int TMAX = SHOW_CYCLES > BLANK_CYCLES
                      ? (SHOW_CYCLES > RESULT_CYCLES ? SHOW_CYCLES : RESULT_CYCLES)
                      : (BLANK_CYCLES > RESULT_CYCLES ? BLANK_CYCLES : RESULT_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    pat_q, pat_d, guess_q, guess_d, sw_s1_q, sw_s2_q;
  logic [6:0]    correct_q, correct_d, incorrect_q, incorrect_d, percent_q, percent_d;
  logic [6:0]    c_new, i_new, quo;
  logic          ok_q, ok_d, done_q, done_d, hit, tdone, div_done;
  logic [3:1]    key_s1_q, key_s2_q, deb_q, deb_d, press;
  logic [CW-1:0] cnt_q [3:1];
  logic [CW-1:0] cnt_d [3:1];
  int            lim;
  always_comb begin
    deb_d = deb_q;
    for (int i = 1; i <= 3; i++) begin
      cnt_d[i] = '0;
      if (key_s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) deb_d[i] = key_s2_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end
  assign press = deb_q & ~deb_d;
  assign hit   = guess_q == pat_q;
  assign c_new = hit && correct_q != 7'(MAX_COUNT) ? correct_q + 7'd1 : correct_q;
  assign i_new = !hit && incorrect_q != 7'(MAX_COUNT) ? incorrect_q + 7'd1 : incorrect_q;
  assign lim   = state_q == SHOW ? SHOW_CYCLES : state_q == BLANK ? BLANK_CYCLES : RESULT_CYCLES;
  assign tdone = timer_q == TW'(lim - 1);
  pct_divider u_div (
    .clk  (clock_50M),
    .rst  (reset),
    .start(state_q == CHECK),
    .num  (14'(c_new) * 14'(PCT_SCALE)),
    .den  ({1'b0, c_new} + {1'b0, i_new}),
    .done (div_done),
    .quo  (quo)
  );
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pat_d       = pat_q;
    guess_d     = guess_q;
    correct_d   = correct_q;
    incorrect_d = incorrect_q;
    percent_d   = percent_q;
    ok_d        = ok_q;
    done_d      = state_q == DIV && div_done;
    case (state_q)
      IDLE: if (pattern_valid) begin
        pat_d   = pattern;
        timer_d = '0;
        state_d = SHOW;
      end
      SHOW, BLANK, RESULT: begin
        timer_d = tdone ? '0 : timer_q + TW'(1);
        if (tdone) state_d = state_q == SHOW ? BLANK : state_q == BLANK ? WAIT_KEY : IDLE;
      end
      WAIT_KEY: if (press[KEY_SUBMIT]) begin
        guess_d = sw_s2_q;
        state_d = CHECK;
      end else if (press[KEY_REPLAY]) begin
        timer_d = '0;
        state_d = SHOW;
      end
      CHECK: begin
        ok_d        = hit;
        correct_d   = c_new;
        incorrect_d = i_new;
        state_d     = DIV;
      end
      DIV: if (div_done) begin
        percent_d = quo;
        state_d   = RESULT;
      end
      default: state_d = IDLE;
    endcase
    if (press[KEY_CLEAR] && (state_q == IDLE || state_q == WAIT_KEY)) begin
      correct_d   = '0;
      incorrect_d = '0;
      percent_d   = '0;
    end
  end
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      pat_q       <= '0;
      guess_q     <= '0;
      correct_q   <= '0;
      incorrect_q <= '0;
      percent_q   <= '0;
      ok_q        <= 1'b0;
      done_q      <= 1'b0;
      key_s1_q    <= '1;
      key_s2_q    <= '1;
      deb_q       <= '1;
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      for (int i = 1; i <= 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pat_q       <= pat_d;
      guess_q     <= guess_d;
      correct_q   <= correct_d;
      incorrect_q <= incorrect_d;
      percent_q   <= percent_d;
      ok_q        <= ok_d;
      done_q      <= done_d;
      key_s1_q    <= key;
      key_s2_q    <= key_s1_q;
      deb_q       <= deb_d;
      sw_s1_q     <= sw;
      sw_s2_q     <= sw_s1_q;
      for (int i = 1; i <= 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign pattern_ready = state_q == IDLE;
  assign led           = state_q == SHOW ? pat_q : state_q == RESULT ? guess_q ^ pat_q : '0;
  assign display_state = state_q;
  assign correct       = correct_q;
  assign incorrect     = incorrect_q;
  assign percent       = percent_q;
  assign round_done    = done_q;
  assign round_ok      = ok_q;
endmodule

// File: tb/tb_memory_round_ctrl.sv
// tb_memory_round_ctrl: randomized self-checking bench scored against a round-level model
module tb_memory_round_ctrl;
  import memory_game_pkg::*;
  localparam int SHOW_N = 4, BLANK_N = 2, RESULT_N = 3, DEB_N = 2, MAXC = 99;
  localparam int M_REPLAY = 1, M_BOTH = 2, M_GC = 4, M_NOISY = 8;
  logic       clk = 1'b0, rst = 1'b1;
  logic [9:0] pattern = '0, sw = '0, led;
  logic       pattern_valid = 1'b0, pattern_ready, round_done, round_ok;
  logic [3:1] key = 3'b111;
  logic [2:0] display_state;
  logic [6:0] correct, incorrect, percent;
  int n_chk = 0, n_pass = 0, rd_cnt = 0, mc = 0, mi = 0;
  memory_round_ctrl #(
    .SHOW_CYCLES(SHOW_N), .BLANK_CYCLES(BLANK_N), .RESULT_CYCLES(RESULT_N),
    .DEB_CYCLES(DEB_N), .MAX_COUNT(MAXC)
  ) dut (
    .clock_50M(clk), .reset(rst), .pattern(pattern), .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready), .sw(sw), .key(key), .led(led),
    .display_state(display_state), .correct(correct), .incorrect(incorrect),
    .percent(percent), .round_done(round_done), .round_ok(round_ok)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (round_done === 1'b1) rd_cnt <= rd_cnt + 1;
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int exp_pct();
    return (mc + mi) == 0 ? 0 : mc * 100 / (mc + mi);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_state(input state_t s, input string tag);
    int n = 0;
    while (display_state != s && n < 100) begin
      tick();
      n++;
    end
    chk(tag, display_state, s);
  endtask
  task automatic measure(input state_t s, input logic [9:0] exp_led, input int len, input string tag);
    int n = 0, bad = 0;
    while (display_state == s && n < 100) begin
      if (led !== exp_led) bad++;
      n++;
      tick();
    end
    chk({tag, "_len"}, n, len);
    chk({tag, "_led"}, bad, 0);
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, display_state, IDLE);
    chk({tag, "_ready"}, pattern_ready, 1);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_correct"}, correct, 0);
    chk({tag, "_incorrect"}, incorrect, 0);
    chk({tag, "_percent"}, percent, 0);
    chk({tag, "_ok"}, round_ok, 0);
  endtask
  task automatic transfer(input logic [9:0] p);
    wait_state(IDLE, "xfer_idle");
    pattern = p;
    pattern_valid = 1'b1;
    tick();
    pattern_valid = 1'b0;
  endtask
  task automatic play_round(input logic [9:0] pat, input logic [9:0] guess, input int mode);
    int rd0, n;
    rd0 = rd_cnt;
    sw = guess;
    wait_state(IDLE, "idle");
    pattern = pat;
    pattern_valid = 1'b1;
    tick();
    if ((mode & M_NOISY) != 0) pattern = ~pat;
    else pattern_valid = 1'b0;
    measure(SHOW, pat, SHOW_N, "show");
    measure(BLANK, '0, BLANK_N, "blank");
    pattern_valid = 1'b0;
    chk("wait_key", display_state, WAIT_KEY);
    if ((mode & M_REPLAY) != 0) begin
      key = 3'b101;
      wait_state(SHOW, "replay");
      key = 3'b111;
      measure(SHOW, pat, SHOW_N, "replay_show");
      measure(BLANK, '0, BLANK_N, "replay_blank");
    end
    if ((mode & M_GC) != 0) begin
      key = 3'b011;
      tick();
      key = 3'b111;
      repeat (6) tick();
      chk("glitch_state", display_state, WAIT_KEY);
      key = 3'b110;
      repeat (5) tick();
      key = 3'b111;
      repeat (5) tick();
      mc = 0;
      mi = 0;
      chk("clr_state", display_state, WAIT_KEY);
      chk("clr_correct", correct, 0);
      chk("clr_incorrect", incorrect, 0);
      chk("clr_percent", percent, 0);
    end
    key = ((mode & M_BOTH) != 0) ? 3'b001 : 3'b011;
    wait_state(CHECK, "check");
    key = 3'b111;
    if (guess == pat) mc = mc < MAXC ? mc + 1 : mc;
    else mi = mi < MAXC ? mi + 1 : mi;
    tick();
    n = 0;
    while (display_state == DIV && n < 20) begin
      tick();
      n++;
    end
    chk("div_lat", int'(n >= 1 && n <= 8), 1);
    chk("result", display_state, RESULT);
    chk("round_ok", round_ok, int'(guess == pat));
    chk("correct", correct, mc);
    chk("incorrect", incorrect, mi);
    chk("percent", percent, exp_pct());
    measure(RESULT, guess ^ pat, RESULT_N, "result");
    chk("round_done", rd_cnt - rd0, 1);
    chk("idle_ready", pattern_ready, 1);
    chk("idle_led", led, 0);
  endtask
  initial begin
    logic [9:0] p, g;
    repeat (3) tick();
    reset_checks("reset");
    chk("reset_done", round_done, 0);
    rst = 1'b0;
    repeat (6) tick();
    play_round(10'h176, 10'h176, 0);
    chk("pct100", percent, 100);
    play_round(10'h00F, 10'h00E, 0);
    chk("pct50", percent, 50);
    p = 10'($urandom);
    play_round(p, p, 0);
    chk("pct66", percent, 66);
    play_round(10'h2A5, 10'h2A5, M_REPLAY);
    play_round(10'h133, 10'h132, M_BOTH);
    play_round(10'h3C3, 10'h3C3, M_GC);
    for (int i = 0; i < 20; i++) begin
      p = 10'($urandom);
      g = $urandom_range(0, 1) ? p : p ^ 10'($urandom_range(1, 1023));
      play_round(p, g, $urandom_range(0, 15));
    end
    p = 10'($urandom);
    play_round(p, p, M_GC);
    for (int i = 0; i < 119; i++) begin
      p = 10'($urandom);
      play_round(p, p, (i % 3 == 0) ? M_NOISY : 0);
    end
    chk("sat_correct", correct, 99);
    chk("sat_percent", percent, 100);
    sw = 10'h155;
    transfer(10'h155);
    wait_state(WAIT_KEY, "div_wait");
    key = 3'b011;
    wait_state(DIV, "to_div");
    rst = 1'b1;
    tick();
    key = 3'b111;
    reset_checks("rst_div");
    rst = 1'b0;
    mc = 0;
    mi = 0;
    repeat (6) tick();
    p = 10'($urandom);
    play_round(p, ~p, 0);
    transfer(10'h0AA);
    tick();
    chk("pre_rst_show", display_state, SHOW);
    rst = 1'b1;
    tick();
    reset_checks("rst_show");
    rst = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
